// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: state encoding and next-PC select codes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } fetchState_t;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;

  // Jump beats branch when both are live in the same cycle.
  function automatic logic [1:0] liveSource(input logic isJump);
    return isJump ? PCSRC_J : PCSRC_BR;
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts consecutive not-ready fetch cycles and flags the one that hits the limit.
// Latency: limitHit is combinational on the cycle the LIMIT-th count is enabled.
// Backpressure: none; clear has priority over count.
module fetch_wait_timer #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic countEn,
  input  logic clear,
  output logic limitHit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] waitCnt;

  // Consecutive-wait counter; clear wins so a ready cycle restarts the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCnt <= '0;
    end else if (clear) begin
      waitCnt <= '0;
    end else if (countEn) begin
      waitCnt <= waitCnt + CW'(1);
    end
  end

  // The current enabled cycle is the LIMIT-th consecutive one.
  assign limitHit = countEn && (waitCnt == CW'(LIMIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: PC/IF-ID enables, redirect select and fetch timeout.
// Latency: control outputs are Mealy (same cycle); fetch_err is registered.
// Backpressure: imem_ready low or stall high hold the PC; redirects override stall.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int WAIT_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic       jump,
  input  logic       imem_ready,
  output logic       imem_req,
  output logic       pcWrite,
  output logic [1:0] PcSrc,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       fetch_err
);

  fetchState_t state;
  fetchState_t nextState;

  logic       pendVld;
  logic [1:0] pendSrc;
  logic       liveRedir;
  logic [1:0] liveSrc;
  logic       haveRedir;
  logic [1:0] redirSrc;
  logic       applyRedir;
  logic       latchLive;
  logic       waitEn;
  logic       waitClr;
  logic       limitHit;

  assign liveRedir = jump | branch_taken;
  assign liveSrc   = liveSource(jump);
  // A pending redirect is older than anything live, so it takes precedence.
  assign haveRedir = pendVld | liveRedir;
  assign redirSrc  = pendVld ? pendSrc : liveSrc;

  assign waitEn  = (state == S_REQ) && !imem_ready;
  assign waitClr = imem_ready || (state != S_REQ);

  fetch_wait_timer #(
    .LIMIT(WAIT_LIMIT)
  ) uWaitTimer (
    .clk     (clk),
    .rst     (rst),
    .countEn (waitEn),
    .clear   (waitClr),
    .limitHit(limitHit)
  );

  // Mealy decode of the fetch controls from state and this cycle's inputs.
  always_comb begin
    nextState  = state;
    imem_req   = 1'b0;
    pcWrite    = 1'b0;
    PcSrc      = PCSRC_SEQ;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    applyRedir = 1'b0;
    latchLive  = 1'b0;
    case (state)
      S_IDLE: begin
        nextState = S_REQ;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          // A redirect makes the stalled instruction wrong-path, so it overrides the stall.
          if (!stall || haveRedir) begin
            pcWrite    = 1'b1;
            ifid_write = 1'b1;
            applyRedir = haveRedir;
          end else begin
            nextState = S_HOLD;
          end
        end else begin
          latchLive = liveRedir && !pendVld;
          if (limitHit) begin
            nextState = S_ERR;
          end
        end
      end
      S_HOLD: begin
        if (!stall || haveRedir) begin
          pcWrite    = 1'b1;
          ifid_write = 1'b1;
          applyRedir = haveRedir;
          nextState  = S_REQ;
        end
      end
      S_ERR: begin
        nextState = S_ERR;
      end
      default: begin
        nextState = S_IDLE;
      end
    endcase
    // Flush only ever rides along with a PC load.
    if (applyRedir) begin
      PcSrc      = redirSrc;
      ifid_flush = 1'b1;
    end
  end

  // State, pending redirect and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pendVld   <= 1'b0;
      pendSrc   <= PCSRC_SEQ;
      fetch_err <= 1'b0;
    end else begin
      state <= nextState;
      if (applyRedir) begin
        pendVld <= 1'b0;
      end else if (latchLive) begin
        pendVld <= 1'b1;
        pendSrc <= liveSrc;
      end
      fetch_err <= fetch_err | (nextState == S_ERR);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expected outputs.
// Output vector order: {imem_req, pcWrite, PcSrc[1:0], ifid_write, ifid_flush, fetch_err}.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       branch_taken;
  logic       jump;
  logic       imem_ready;
  logic       imem_req;
  logic       pcWrite;
  logic [1:0] PcSrc;
  logic       ifid_write;
  logic       ifid_flush;
  logic       fetch_err;

  int checks   = 0;
  int failures = 0;

  logic [6:0] obs;
  assign obs = {imem_req, pcWrite, PcSrc, ifid_write, ifid_flush, fetch_err};

  // Expected patterns
  localparam logic [6:0] ALL0   = 7'b0_0_00_0_0_0;
  localparam logic [6:0] FETCH  = 7'b1_1_00_1_0_0;
  localparam logic [6:0] WAITNG = 7'b1_0_00_0_0_0;
  localparam logic [6:0] FBR    = 7'b1_1_01_1_1_0;
  localparam logic [6:0] FJ     = 7'b1_1_10_1_1_0;
  localparam logic [6:0] ERR    = 7'b0_0_00_0_0_1;
  localparam logic [6:0] HOLDX  = 7'b0_1_00_1_0_0;
  localparam logic [6:0] NOREQ  = 7'b0_1_11_1_1_1;

  fetch_sequencer #(.WAIT_LIMIT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .branch_taken(branch_taken),
    .jump        (jump),
    .imem_ready  (imem_ready),
    .imem_req    (imem_req),
    .pcWrite     (pcWrite),
    .PcSrc       (PcSrc),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp, input logic [6:0] mask);
    @(negedge clk);
    checks++;
    assert ((obs & mask) === (exp & mask)) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b mask=%b", tag, obs, exp, mask);
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_ready = 1'b1;
    tick();
    tick();
    chk("reset_outputs", ALL0, 7'h7f);

    // Release: first cycle idle, then one fetch per cycle
    tick();
    rst = 1'b1;
    chk("idle_cycle1", ALL0, 7'h7f);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("seq_fetch_%0d", i), FETCH, 7'h7f);
      tick();
    end

    // Branch while memory not ready: latched, applied when ready
    imem_ready = 1'b0; branch_taken = 1'b1;
    chk("wait_br_c1", WAITNG, 7'h7f);
    tick();
    branch_taken = 1'b0;
    chk("wait_br_c2", WAITNG, 7'h7f);
    tick();
    chk("wait_br_c3", WAITNG, 7'h7f);
    tick();
    imem_ready = 1'b1;
    chk("pending_br_apply", FBR, 7'h7f);
    tick();
    chk("pending_br_cleared", FETCH, 7'h7f);
    tick();

    // Load-use stall with ready memory: hold, then resume
    stall = 1'b1;
    chk("stall_enter", WAITNG, 7'h7f);
    tick();
    chk("stall_hold", ALL0, 7'h7f);
    tick();
    stall = 1'b0;
    chk("stall_exit", HOLDX, NOREQ);
    tick();
    chk("stall_resume", FETCH, 7'h7f);
    tick();

    // Tie between branch and jump: jump wins
    branch_taken = 1'b1; jump = 1'b1;
    chk("tie_jump_wins", FJ, 7'h7f);
    tick();
    branch_taken = 1'b0; jump = 1'b0;
    chk("tie_after", FETCH, 7'h7f);
    tick();

    // Jump latched while waiting; branch next cycle is wrong-path
    imem_ready = 1'b0; jump = 1'b1;
    chk("wait_j_c1", WAITNG, 7'h7f);
    tick();
    jump = 1'b0; branch_taken = 1'b1;
    chk("wait_j_c2_br_ignored", WAITNG, 7'h7f);
    tick();
    branch_taken = 1'b0; imem_ready = 1'b1;
    chk("pending_j_apply", FJ, 7'h7f);
    tick();
    chk("pending_j_cleared", FETCH, 7'h7f);
    tick();

    // Timeout: 8 not-ready fetch cycles, then sticky error
    imem_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("timeout_wait_%0d", i), WAITNG, 7'h7f);
      tick();
    end
    chk("timeout_err_set", ERR, 7'h7f);
    tick();
    imem_ready = 1'b1; jump = 1'b1;
    chk("err_sticky_ready", ERR, 7'h7f);
    tick();
    jump = 1'b0;
    chk("err_sticky_2", ERR, 7'h7f);
    #2;
    rst = 1'b0;
    chk("err_cleared_by_reset", ALL0, 7'h7f);
    tick();
    rst = 1'b1;
    chk("idle_after_err_reset", ALL0, 7'h7f);
    tick();
    chk("fetch_after_err_reset", FETCH, 7'h7f);
    tick();

    // Reset mid-wait with a jump pending: pending must be discarded
    imem_ready = 1'b0; jump = 1'b1;
    chk("rst_wait_c1", WAITNG, 7'h7f);
    tick();
    jump = 1'b0;
    chk("rst_wait_c2", WAITNG, 7'h7f);
    #2;
    rst = 1'b0;
    chk("async_reset_midwait", ALL0, 7'h7f);
    tick();
    rst = 1'b1; imem_ready = 1'b1;
    chk("idle_after_midwait_reset", ALL0, 7'h7f);
    tick();
    chk("no_stale_jump", FETCH, 7'h7f);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter WAIT_LIMIT, default 8, giving the maximum consecutive not-ready instruction-memory cycles before an error.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port stall, input, 1, a load-use hazard stall request.
REQ-005 The block SHALL have port branch_taken, input, 1, a single-cycle pulse marking a taken branch resolved in ID.
REQ-006 The block SHALL have port jump, input, 1, a single-cycle pulse marking a jump decoded in ID.
REQ-007 The block SHALL have port imem_ready, input, 1, meaning the instruction word at the current PC is valid this cycle.
REQ-008 The block SHALL have port imem_req, output, 1, the fetch request to instruction memory.
REQ-009 The block SHALL have port pcWrite, output, 1, the PC load enable.
REQ-010 The block SHALL have port PcSrc, output, 2, the next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target; 11 is never driven.
REQ-011 The block SHALL have port ifid_write, output, 1, the IF/ID register load enable.
REQ-012 The block SHALL have port ifid_flush, output, 1, which loads a bubble into IF/ID; flush overrides write.
REQ-013 The block SHALL have port fetch_err, output, 1, a sticky registered fetch-timeout flag.

Function
REQ-014 States SHALL be S_IDLE, S_REQ, S_HOLD and S_ERR; outputs other than fetch_err are Mealy, decoded from state and the current-cycle inputs.
REQ-015 Live redirect = jump | branch_taken; jump SHALL win a tie, so PcSrc=10.
REQ-016 Pending register: a live redirect that cannot be applied in its cycle SHALL be latched (valid + source); while pending is valid, further redirects SHALL be ignored as wrong-path.
REQ-017 Redirect source SHALL be pending if valid, else live; applying it SHALL drive PcSrc=source and ifid_flush=1, and clear pending at the clock edge.
REQ-018 S_IDLE: all outputs SHALL be 0 and redirects ignored; next state SHALL be S_REQ unconditionally.
REQ-019 S_REQ: imem_req=1.
REQ-019a S_REQ with imem_ready=1 and stall=0: pcWrite=1 and ifid_write=1, redirect applied if any; remain in S_REQ, giving one fetch per cycle.
REQ-019b S_REQ with imem_ready=1 and stall=1: if a redirect exists, apply it (pcWrite=1, flush=1), overriding the stall, and remain in S_REQ; otherwise pcWrite=0 and ifid_write=0, and go to S_HOLD.
REQ-019c S_REQ with imem_ready=0: pcWrite=0 and ifid_write=0; latch any live redirect; increment the wait counter.
REQ-020 S_HOLD: imem_req=0 and pcWrite=0 while stall=1 and no redirect.
REQ-020a S_HOLD exit: on stall=0 or any redirect, drive pcWrite=1 and ifid_write=1 (applying the redirect if any) and go to S_REQ.
REQ-021 The wait counter SHALL clear on any cycle with imem_ready=1 or any state other than S_REQ; when WAIT_LIMIT consecutive not-ready S_REQ cycles have elapsed, next state SHALL be S_ERR.
REQ-022 S_ERR: all outputs SHALL be 0 except fetch_err=1, which is registered and goes high the first cycle in S_ERR; S_ERR SHALL be left only by reset.
REQ-023 ifid_flush SHALL never assert without pcWrite in the same cycle.

Reset
REQ-024 rst=0 SHALL force asynchronously: state S_IDLE, pending cleared, counter 0, fetch_err 0, all outputs 0, including when asserted mid-wait or with a redirect pending.
REQ-025 After rst deasserts, the first cycle SHALL be S_IDLE; fetching SHALL begin the following cycle.

Structure
REQ-026 The shared package SHALL hold the state encoding and the PcSrc constants PCSRC_SEQ=00, PCSRC_BR=01 and PCSRC_J=10.
REQ-027 The wait counter SHALL be one sub-module, fetch_wait_timer (inputs: clk, rst, count enable, clear; output: limit reached), sized clog2(WAIT_LIMIT+1).

Verification
REQ-028 Release reset with imem_ready=1, stall=0 -> cycle 1 all outputs 0; from cycle 2, pcWrite=1 and PcSrc=00 every cycle.
REQ-029 imem_ready=0 for 3 cycles with a branch_taken pulse in the first -> pcWrite=0 for 3 cycles; in cycle 4 with ready=1, pcWrite=1, PcSrc=01, ifid_flush=1, then pending is clear.
REQ-030 imem_ready=1 with stall=1 for 2 cycles -> S_HOLD, pcWrite=0 and imem_req=0; when stall drops, pcWrite=1 and ifid_write=1, then back to S_REQ.
REQ-031 branch_taken=1 and jump=1 in the same ready cycle -> PcSrc=10 and ifid_flush=1; a branch one cycle later while waiting is ignored.
REQ-032 WAIT_LIMIT=8 with imem_ready held 0 -> fetch_err=1 from the 9th S_REQ cycle, all other outputs 0; it stays set with ready=1 and clears only on rst=0.
REQ-033 rst=0 mid-wait with a jump pending -> after release, the first pcWrite carries PcSrc=00 and ifid_flush=0.
